// File: rtl/or32_bus_pkg.sv
// Shared types for the or32 two-master bus arbiter.
//  - FSM state encoding (ST_IDLE, ST_BUSY)
//  - master id constants M0 (core) and M1 (secondary requester)
//  - req_t: captured request record (addr, dat_w, we)
package or32_bus_pkg;

   localparam int unsigned REQ_AW = 32;
   localparam int unsigned REQ_DW = 32;
   localparam int unsigned REQ_BW = REQ_DW / 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef struct packed {
      logic [REQ_AW-1:0] addr;
      logic [REQ_DW-1:0] dat_w;
      logic [REQ_BW-1:0] we;
   } req_t;

endpackage

// File: rtl/or32_bus_req_slot.sv
// One request slot: captures a master's strobe payload and holds it until
// the arbiter frees the slot on completion.
// Ports:
//  i_clk, i_rst        clock, async active-high reset
//  i_stb               one-cycle request strobe from the master
//  i_addr/i_dat_w/i_we request payload, sampled with i_stb
//  i_free              completion of this slot's transaction
//  o_pending           slot occupied (waiting or in flight)
//  o_addr/o_dat_w/o_we captured payload
module or32_bus_req_slot
   import or32_bus_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_stb,
   input  logic [REQ_AW-1:0] i_addr,
   input  logic [REQ_DW-1:0] i_dat_w,
   input  logic [REQ_BW-1:0] i_we,
   input  logic              i_free,
   output logic              o_pending,
   output logic [REQ_AW-1:0] o_addr,
   output logic [REQ_DW-1:0] o_dat_w,
   output logic [REQ_BW-1:0] o_we
);

   logic pending_q;
   req_t req_q;

   // A strobe on an occupied slot is a protocol violation and is dropped.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pending_q <= 1'b0;
         req_q     <= '0;
      end else if (i_free) begin
         pending_q <= 1'b0;
      end else if (i_stb && !pending_q) begin
         pending_q   <= 1'b1;
         req_q.addr  <= i_addr;
         req_q.dat_w <= i_dat_w;
         req_q.we    <= i_we;
      end
   end

   assign o_pending = pending_q;
   assign o_addr    = req_q.addr;
   assign o_dat_w   = req_q.dat_w;
   assign o_we      = req_q.we;

endmodule

// File: rtl/or32_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the or32 strobe/ack bus.
// Each master's strobe is captured in a slot; granted requests are replayed
// on the slave port and the response is routed back to the owner only.
// Ports:
//  i_clk, i_rst                      clock, async active-high reset
//  i_mX_addr/dat_w/we/stb            master X request (X = 0 core, 1 secondary)
//  o_mX_dat_r/o_mX_ack               master X response
//  o_addr/o_dat_w/o_we/o_stb         slave request
//  i_dat_r/i_ack                     slave response
//  o_owner                           master of the current or last transaction
//  o_timeout                         pulse on a forced completion
module or32_bus_arbiter
   import or32_bus_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [AW-1:0]   i_m0_addr,
   input  logic [DW-1:0]   i_m0_dat_w,
   input  logic [DW/8-1:0] i_m0_we,
   input  logic            i_m0_stb,
   output logic [DW-1:0]   o_m0_dat_r,
   output logic            o_m0_ack,
   input  logic [AW-1:0]   i_m1_addr,
   input  logic [DW-1:0]   i_m1_dat_w,
   input  logic [DW/8-1:0] i_m1_we,
   input  logic            i_m1_stb,
   output logic [DW-1:0]   o_m1_dat_r,
   output logic            o_m1_ack,
   output logic [AW-1:0]   o_addr,
   output logic [DW-1:0]   o_dat_w,
   output logic [DW/8-1:0] o_we,
   output logic            o_stb,
   input  logic [DW-1:0]   i_dat_r,
   input  logic            i_ack,
   output logic            o_owner,
   output logic            o_timeout
);

   localparam int unsigned BW = DW / 8;
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e            state_q;
   logic              last_q;
   logic [CW-1:0]     tmo_cnt_q, tmo_cnt_d;

   logic              m0_pend, m1_pend;
   logic [REQ_AW-1:0] m0_addr, m1_addr;
   logic [REQ_DW-1:0] m0_dat_w, m1_dat_w;
   logic [REQ_BW-1:0] m0_we, m1_we;

   logic              grant_c, grant_id_c;
   logic              tmo_hit_c, done_c;
   logic              m0_free_c, m1_free_c;
   logic [REQ_AW-1:0] sel_addr_c;
   logic [REQ_DW-1:0] sel_dat_w_c;
   logic [REQ_BW-1:0] sel_we_c;

   or32_bus_req_slot u_slot_m0 (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_stb     (i_m0_stb),
      .i_addr    (REQ_AW'(i_m0_addr)),
      .i_dat_w   (REQ_DW'(i_m0_dat_w)),
      .i_we      (REQ_BW'(i_m0_we)),
      .i_free    (m0_free_c),
      .o_pending (m0_pend),
      .o_addr    (m0_addr),
      .o_dat_w   (m0_dat_w),
      .o_we      (m0_we)
   );

   or32_bus_req_slot u_slot_m1 (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_stb     (i_m1_stb),
      .i_addr    (REQ_AW'(i_m1_addr)),
      .i_dat_w   (REQ_DW'(i_m1_dat_w)),
      .i_we      (REQ_BW'(i_m1_we)),
      .i_free    (m1_free_c),
      .o_pending (m1_pend),
      .o_addr    (m1_addr),
      .o_dat_w   (m1_dat_w),
      .o_we      (m1_we)
   );

   // Grant selection, completion detect and timeout counter next value.
   always_comb begin
      grant_c    = 1'b0;
      grant_id_c = M0;
      if (state_q == ST_IDLE) begin
         if (m0_pend && m1_pend) begin
            grant_c    = 1'b1;
            grant_id_c = ~last_q;
         end else if (m0_pend) begin
            grant_c    = 1'b1;
            grant_id_c = M0;
         end else if (m1_pend) begin
            grant_c    = 1'b1;
            grant_id_c = M1;
         end
      end

      sel_addr_c  = (grant_id_c == M1) ? m1_addr  : m0_addr;
      sel_dat_w_c = (grant_id_c == M1) ? m1_dat_w : m0_dat_w;
      sel_we_c    = (grant_id_c == M1) ? m1_we    : m0_we;

      // A real ack in the expiry cycle wins over the forced completion.
      tmo_hit_c = (TIMEOUT != 0) && (tmo_cnt_q == CW'(TIMEOUT - 1));
      done_c    = (state_q == ST_BUSY) && (i_ack || tmo_hit_c);
      m0_free_c = done_c && (o_owner == M0);
      m1_free_c = done_c && (o_owner == M1);

      tmo_cnt_d = tmo_cnt_q;
      if (grant_c) begin
         tmo_cnt_d = '0;
      end else if ((state_q == ST_BUSY) && !done_c) begin
         tmo_cnt_d = tmo_cnt_q + CW'(1);
      end
   end

   // Arbiter FSM with registered slave and response outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         last_q     <= M1;
         tmo_cnt_q  <= '0;
         o_addr     <= '0;
         o_dat_w    <= '0;
         o_we       <= '0;
         o_stb      <= 1'b0;
         o_owner    <= M0;
         o_m0_dat_r <= '0;
         o_m0_ack   <= 1'b0;
         o_m1_dat_r <= '0;
         o_m1_ack   <= 1'b0;
         o_timeout  <= 1'b0;
      end else begin
         o_stb     <= 1'b0;
         o_m0_ack  <= 1'b0;
         o_m1_ack  <= 1'b0;
         o_timeout <= 1'b0;
         tmo_cnt_q <= tmo_cnt_d;
         case (state_q)
            ST_IDLE: begin
               if (grant_c) begin
                  o_addr  <= AW'(sel_addr_c);
                  o_dat_w <= DW'(sel_dat_w_c);
                  o_we    <= BW'(sel_we_c);
                  o_stb   <= 1'b1;
                  o_owner <= grant_id_c;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (done_c) begin
                  if (o_owner == M0) begin
                     o_m0_ack   <= 1'b1;
                     o_m0_dat_r <= i_ack ? i_dat_r : '0;
                  end else begin
                     o_m1_ack   <= 1'b1;
                     o_m1_dat_r <= i_ack ? i_dat_r : '0;
                  end
                  o_timeout <= !i_ack;
                  o_we      <= '0;
                  last_q    <= o_owner;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_or32_bus_arbiter.sv
// Self-checking bench for or32_bus_arbiter (TIMEOUT = 8).
// A slave model answers each o_stb after slv_delay cycles with data
// slv_data ^ o_addr; a monitor pops expected slave transactions and master
// responses from scoreboard queues as the DUT produces them.
`timescale 1ns/1ps
module tb_or32_bus_arbiter;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 8;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] dat;
      logic [3:0]  we;
      logic        owner;
   } tx_t;

   typedef struct packed {
      logic        m;
      logic [31:0] dat;
      logic        tmo;
   } ack_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_m0_addr, i_m0_dat_w, o_m0_dat_r;
   logic [3:0]  i_m0_we;
   logic        i_m0_stb, o_m0_ack;
   logic [31:0] i_m1_addr, i_m1_dat_w, o_m1_dat_r;
   logic [3:0]  i_m1_we;
   logic        i_m1_stb, o_m1_ack;
   logic [31:0] o_addr, o_dat_w, i_dat_r;
   logic [3:0]  o_we;
   logic        o_stb, i_ack, o_owner, o_timeout;

   tx_t  exp_tx_q[$];
   ack_t exp_ack_q[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          stb_cyc = 0;
   int          ack_cyc = 0;
   int          n_stb = 0;
   int          n_ack = 0;
   int          slv_delay = 0;
   logic [31:0] slv_data = '0;

   always #5 clk = ~clk;

   or32_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_m0_addr  (i_m0_addr),
      .i_m0_dat_w (i_m0_dat_w),
      .i_m0_we    (i_m0_we),
      .i_m0_stb   (i_m0_stb),
      .o_m0_dat_r (o_m0_dat_r),
      .o_m0_ack   (o_m0_ack),
      .i_m1_addr  (i_m1_addr),
      .i_m1_dat_w (i_m1_dat_w),
      .i_m1_we    (i_m1_we),
      .i_m1_stb   (i_m1_stb),
      .o_m1_dat_r (o_m1_dat_r),
      .o_m1_ack   (o_m1_ack),
      .o_addr     (o_addr),
      .o_dat_w    (o_dat_w),
      .o_we       (o_we),
      .o_stb      (o_stb),
      .i_dat_r    (i_dat_r),
      .i_ack      (i_ack),
      .o_owner    (o_owner),
      .o_timeout  (o_timeout)
   );

   // Advance to just after the next rising edge; strobes last one cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      i_m0_stb = 1'b0;
      i_m1_stb = 1'b0;
   endtask

   // Raise a master strobe and record the slave transaction it must cause.
   task automatic req(input logic m, input logic [31:0] addr, input logic [31:0] dat,
                      input logic [3:0] we);
      if (m) begin
         i_m1_addr = addr; i_m1_dat_w = dat; i_m1_we = we; i_m1_stb = 1'b1;
      end else begin
         i_m0_addr = addr; i_m0_dat_w = dat; i_m0_we = we; i_m0_stb = 1'b1;
      end
      exp_tx_q.push_back('{addr: addr, dat: dat, we: we, owner: m});
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_m0_addr = '0; i_m0_dat_w = '0; i_m0_we = '0; i_m0_stb = 1'b0;
      i_m1_addr = '0; i_m1_dat_w = '0; i_m1_we = '0; i_m1_stb = 1'b0;
      repeat (3) tick();
      checks++;
      if ({o_stb, o_m0_ack, o_m1_ack, o_owner, o_timeout} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: stb/ack0/ack1/owner/tmo=%b required 00000",
                  {o_stb, o_m0_ack, o_m1_ack, o_owner, o_timeout});
      end
      checks++;
      if ({o_addr, o_dat_w, o_we, o_m0_dat_r, o_m1_dat_r} !== '0) begin
         errors++;
         $display("FAIL reset_data: addr=%h dat_w=%h we=%h r0=%h r1=%h required all 0",
                  o_addr, o_dat_w, o_we, o_m0_dat_r, o_m1_dat_r);
      end
      rst = 1'b0;
      repeat (3) tick();
      checks++;
      if (o_stb !== 1'b0 || n_stb != 0) begin
         errors++;
         $display("FAIL reset_idle: o_stb=%b n_stb=%0d required 0 with no request", o_stb, n_stb);
      end
   endtask

   task automatic test_single_read();
      int k;
      slv_delay = 0;
      slv_data  = 32'hCAFEF00D ^ 32'h100;
      k = cyc;
      req(1'b0, 32'h100, 32'h0, 4'h0);
      exp_ack_q.push_back('{m: 1'b0, dat: 32'hCAFEF00D, tmo: 1'b0});
      for (int i = 0; i < 40 && (exp_tx_q.size() + exp_ack_q.size()) != 0; i++) tick();
      checks++;
      if (exp_tx_q.size() + exp_ack_q.size() != 0) begin
         errors++;
         $display("FAIL read_drain: %0d outstanding required 0", exp_tx_q.size() + exp_ack_q.size());
      end
      checks++;
      if (stb_cyc != k + 2) begin
         errors++;
         $display("FAIL read_stb_latency: o_stb at cycle %0d required %0d", stb_cyc, k + 2);
      end
      checks++;
      if (ack_cyc != stb_cyc + 1) begin
         errors++;
         $display("FAIL read_ack_latency: ack at cycle %0d required %0d", ack_cyc, stb_cyc + 1);
      end
      repeat (3) tick();
      checks++;
      if (o_m0_dat_r !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL read_dat_hold: o_m0_dat_r=%h required cafef00d", o_m0_dat_r);
      end
   endtask

   task automatic test_round_robin();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      slv_delay = 2;
      slv_data  = 32'h11110000;
      // Fresh pointer favours M0.
      req(1'b0, 32'h1000, 32'hA0, 4'h0);
      req(1'b1, 32'h2000, 32'hB0, 4'h0);
      exp_ack_q.push_back('{m: 1'b0, dat: 32'h11111000, tmo: 1'b0});
      exp_ack_q.push_back('{m: 1'b1, dat: 32'h11112000, tmo: 1'b0});
      for (int i = 0; i < 60 && (exp_tx_q.size() + exp_ack_q.size()) != 0; i++) tick();
      // A lone M0 transaction leaves M0 as last granted.
      req(1'b0, 32'h1004, 32'hA1, 4'h0);
      exp_ack_q.push_back('{m: 1'b0, dat: 32'h11111004, tmo: 1'b0});
      for (int i = 0; i < 40 && (exp_tx_q.size() + exp_ack_q.size()) != 0; i++) tick();
      // Both pending again: M1 goes first this time.
      req(1'b0, 32'h1008, 32'hA2, 4'h0);
      req(1'b1, 32'h2008, 32'hB2, 4'h0);
      exp_tx_q.delete();
      exp_tx_q.push_back('{addr: 32'h2008, dat: 32'hB2, we: 4'h0, owner: 1'b1});
      exp_tx_q.push_back('{addr: 32'h1008, dat: 32'hA2, we: 4'h0, owner: 1'b0});
      exp_ack_q.push_back('{m: 1'b1, dat: 32'h11112008, tmo: 1'b0});
      exp_ack_q.push_back('{m: 1'b0, dat: 32'h11111008, tmo: 1'b0});
      for (int i = 0; i < 60 && (exp_tx_q.size() + exp_ack_q.size()) != 0; i++) tick();
      checks++;
      if (exp_tx_q.size() + exp_ack_q.size() != 0) begin
         errors++;
         $display("FAIL rr_drain: %0d outstanding required 0", exp_tx_q.size() + exp_ack_q.size());
      end
   endtask

   task automatic test_byte_write();
      slv_delay = 2;
      slv_data  = 32'h0;
      req(1'b1, 32'h202, 32'h00AB0000, 4'b0100);
      exp_ack_q.push_back('{m: 1'b1, dat: 32'h202, tmo: 1'b0});
      repeat (3) tick();
      checks++;
      if (o_stb !== 1'b0 || o_we !== 4'b0100 || o_addr !== 32'h202 || o_dat_w !== 32'h00AB0000) begin
         errors++;
         $display("FAIL write_hold: stb=%b we=%b addr=%h dat=%h required 0 0100 202 00ab0000",
                  o_stb, o_we, o_addr, o_dat_w);
      end
      for (int i = 0; i < 40 && (exp_tx_q.size() + exp_ack_q.size()) != 0; i++) tick();
      checks++;
      if (exp_tx_q.size() + exp_ack_q.size() != 0 || o_we !== 4'b0 || o_owner !== 1'b1) begin
         errors++;
         $display("FAIL write_done: outstanding=%0d we=%b owner=%b required 0 0000 1",
                  exp_tx_q.size() + exp_ack_q.size(), o_we, o_owner);
      end
   endtask

   task automatic test_timeout();
      // Slave answers after 10 cycles: forced completion first, late ack ignored.
      slv_delay = 10;
      slv_data  = 32'hFFFF0000;
      req(1'b0, 32'h300, 32'h0, 4'h0);
      exp_ack_q.push_back('{m: 1'b0, dat: 32'h0, tmo: 1'b1});
      for (int i = 0; i < 40 && (exp_tx_q.size() + exp_ack_q.size()) != 0; i++) tick();
      checks++;
      if (exp_ack_q.size() != 0 || ack_cyc != stb_cyc + 8) begin
         errors++;
         $display("FAIL tmo_latency: ack at cycle %0d required %0d (outstanding %0d)",
                  ack_cyc, stb_cyc + 8, exp_ack_q.size());
      end
      repeat (5) tick();
      slv_delay = 1;
      slv_data  = 32'h12340000;
      req(1'b1, 32'h304, 32'h0, 4'h0);
      exp_ack_q.push_back('{m: 1'b1, dat: 32'h12340304, tmo: 1'b0});
      for (int i = 0; i < 40 && (exp_tx_q.size() + exp_ack_q.size()) != 0; i++) tick();
      // Ack exactly in the expiry cycle counts as a normal completion.
      slv_delay = 7;
      slv_data  = 32'h55550000;
      req(1'b0, 32'h308, 32'h0, 4'h0);
      exp_ack_q.push_back('{m: 1'b0, dat: 32'h55550308, tmo: 1'b0});
      for (int i = 0; i < 40 && (exp_tx_q.size() + exp_ack_q.size()) != 0; i++) tick();
      checks++;
      if (exp_tx_q.size() + exp_ack_q.size() != 0 || ack_cyc != stb_cyc + 8) begin
         errors++;
         $display("FAIL tmo_boundary: ack at cycle %0d required %0d (outstanding %0d)",
                  ack_cyc, stb_cyc + 8, exp_tx_q.size() + exp_ack_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int s0, a0;
      slv_delay = 100;
      slv_data  = 32'h0;
      req(1'b0, 32'h400, 32'h0, 4'h0);
      tick();
      i_m1_addr = 32'h404; i_m1_dat_w = 32'h0; i_m1_we = 4'h0; i_m1_stb = 1'b1;
      repeat (3) tick();
      checks++;
      if (exp_tx_q.size() != 0 || o_owner !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_setup: outstanding=%0d owner=%b required 0 0", exp_tx_q.size(), o_owner);
      end
      s0 = n_stb;
      a0 = n_ack;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({o_stb, o_we, o_m0_ack, o_m1_ack, o_timeout, o_owner} !== '0 || o_addr !== '0) begin
         errors++;
         $display("FAIL rstmid_async: stb=%b we=%b ack0=%b ack1=%b tmo=%b owner=%b addr=%h required all 0",
                  o_stb, o_we, o_m0_ack, o_m1_ack, o_timeout, o_owner, o_addr);
      end
      repeat (2) tick();
      rst = 1'b0;
      repeat (20) tick();
      checks++;
      if (n_stb != s0 || n_ack != a0) begin
         errors++;
         $display("FAIL rstmid_discard: stb/ack events %0d/%0d required %0d/%0d", n_stb, n_ack, s0, a0);
      end
   endtask

   task automatic test_dup_strobe();
      int s0, a0;
      s0 = n_stb;
      a0 = n_ack;
      slv_delay = 3;
      slv_data  = 32'h0;
      req(1'b0, 32'h500, 32'h0, 4'h0);
      exp_ack_q.push_back('{m: 1'b0, dat: 32'h500, tmo: 1'b0});
      tick();
      i_m0_addr = 32'h5FC; i_m0_stb = 1'b1;
      tick();
      tick();
      i_m0_addr = 32'h5F8; i_m0_stb = 1'b1;
      repeat (15) tick();
      checks++;
      if (n_stb != s0 + 1 || n_ack != a0 + 1 || exp_ack_q.size() != 0) begin
         errors++;
         $display("FAIL dup_strobe: stb/ack events %0d/%0d required %0d/%0d",
                  n_stb - s0, n_ack - a0, 1, 1);
      end
   endtask

   task automatic test_back_to_back();
      int  a1;
      bit  seen;
      slv_delay = 0;
      slv_data  = 32'h0;
      req(1'b0, 32'h600, 32'h0, 4'h0);
      exp_ack_q.push_back('{m: 1'b0, dat: 32'h600, tmo: 1'b0});
      seen = 1'b0;
      a1   = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (o_m0_ack === 1'b1) begin
            seen = 1'b1;
            a1   = cyc;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL b2b_first_ack: no o_m0_ack within 20 cycles, required one");
      end
      // Freed slot captures a strobe in its own ack cycle.
      req(1'b0, 32'h604, 32'h0, 4'h0);
      exp_ack_q.push_back('{m: 1'b0, dat: 32'h604, tmo: 1'b0});
      for (int i = 0; i < 40 && (exp_tx_q.size() + exp_ack_q.size()) != 0; i++) tick();
      checks++;
      if (exp_tx_q.size() + exp_ack_q.size() != 0 || stb_cyc != a1 + 2) begin
         errors++;
         $display("FAIL b2b_latency: second o_stb at cycle %0d required %0d (outstanding %0d)",
                  stb_cyc, a1 + 2, exp_tx_q.size() + exp_ack_q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      fork
         forever begin
            @(posedge clk);
            cyc = cyc + 1;
         end
         // Slave model and scoreboard monitor, sampled on the falling edge.
         begin : mon
            tx_t         t;
            ack_t        a;
            bit          ack_pend;
            int          ack_cnt;
            logic [31:0] ack_dat;
            logic [31:0] got;
            ack_pend = 1'b0;
            ack_cnt  = 0;
            ack_dat  = '0;
            i_ack    = 1'b0;
            i_dat_r  = '0;
            forever begin
               @(negedge clk);
               i_ack = 1'b0;
               if (rst) begin
                  ack_pend = 1'b0;
               end else begin
                  if (o_stb === 1'b1) begin
                     n_stb++;
                     stb_cyc = cyc;
                     checks++;
                     if (exp_tx_q.size() == 0) begin
                        errors++;
                        $display("FAIL slave_tx: unexpected o_stb addr=%h owner=%b, required none", o_addr, o_owner);
                     end else begin
                        t = exp_tx_q.pop_front();
                        if (o_addr !== t.addr || o_dat_w !== t.dat || o_we !== t.we || o_owner !== t.owner) begin
                           errors++;
                           $display("FAIL slave_tx: addr=%h dat=%h we=%b owner=%b required %h %h %b %b",
                                    o_addr, o_dat_w, o_we, o_owner, t.addr, t.dat, t.we, t.owner);
                        end
                     end
                     ack_pend = 1'b1;
                     ack_cnt  = slv_delay;
                     ack_dat  = slv_data ^ o_addr;
                  end
                  if (ack_pend) begin
                     if (ack_cnt == 0) begin
                        i_ack    = 1'b1;
                        i_dat_r  = ack_dat;
                        ack_pend = 1'b0;
                     end else begin
                        ack_cnt--;
                     end
                  end
                  if (o_m0_ack === 1'b1 || o_m1_ack === 1'b1 || o_timeout === 1'b1) begin
                     n_ack++;
                     ack_cyc = cyc;
                     checks++;
                     if (exp_ack_q.size() == 0) begin
                        errors++;
                        $display("FAIL master_resp: unexpected ack0=%b ack1=%b tmo=%b, required none",
                                 o_m0_ack, o_m1_ack, o_timeout);
                     end else begin
                        a   = exp_ack_q.pop_front();
                        got = a.m ? o_m1_dat_r : o_m0_dat_r;
                        if (o_m0_ack !== ~a.m || o_m1_ack !== a.m || got !== a.dat || o_timeout !== a.tmo) begin
                           errors++;
                           $display("FAIL master_resp: ack0=%b ack1=%b dat=%h tmo=%b required %b %b %h %b",
                                    o_m0_ack, o_m1_ack, got, o_timeout, ~a.m, a.m, a.dat, a.tmo);
                        end
                     end
                  end
               end
            end
         end
         begin
            #1_000_000;
            $display("FAIL watchdog: simulation did not complete, required completion");
            $fatal(1, "watchdog expired");
         end
      join_none

      test_reset();
      test_single_read();
      test_round_robin();
      test_byte_write();
      test_timeout();
      test_reset_mid();
      test_dup_strobe();
      test_back_to_back();
      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
